// File: rtl/quad_display_scheduler_pkg.sv
// quad_display_scheduler_pkg: shared display constants, scheduler state encoding and dwell-cycle computation
package quad_display_scheduler_pkg;
    localparam int DIGIT_W = 14;
    localparam logic [DIGIT_W-1:0] DISP_MAX = 14'd9999;
    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;
    function automatic int dwell_cyc(input int clock_freq_hz, input int dwell_ms);
        int c;
        c = clock_freq_hz / 1000 * dwell_ms;
        return c < 1 ? 1 : c;
    endfunction
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: grant dwell counter (clk_i/rst_i, clear restarts at 0, hold freezes; expire high on the last dwell cycle when not held)
module dwell_timer #(
    parameter int DWELL_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic hold,
    output logic expire
);
    localparam int W = DWELL_CYC > 1 ? $clog2(DWELL_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(DWELL_CYC - 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign expire = cnt_q == LAST && !hold;
    always_comb begin
        cnt_d = clear ? '0 : hold ? cnt_q : cnt_q + W'(1);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/quad_display_scheduler.sv
// quad_display_scheduler: round-robin time-sharing of the quad display (clk_i/rst_i, req_valid_i/req_value_i/hold_i in; grant_o/disp_en_o/disp_num_o/dot_enables_o out)
module quad_display_scheduler
    import quad_display_scheduler_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 100_000_000,
    parameter int DWELL_MS      = 1000,
    parameter int NUM_REQ       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DIGIT_W-1:0] req_value_i,
    input  logic                       hold_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic                       disp_en_o,
    output logic [DIGIT_W-1:0]         disp_num_o,
    output logic [3:0]                 dot_enables_o
);
    localparam int DWELL_CYC = dwell_cyc(CLOCK_FREQ_HZ, DWELL_MS);
    state_e state_q, state_d;
    logic [1:0] ptr_q, ptr_d, pick, idx;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [DIGIT_W-1:0] num_q, num_d;
    logic [DIGIT_W-1:0] val [NUM_REQ];
    logic expire, repick, any_valid;
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_val
        assign val[k] = req_value_i[k*DIGIT_W +: DIGIT_W];
    end
    dwell_timer #(.DWELL_CYC(DWELL_CYC)) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (repick),
        .hold   (hold_i),
        .expire (expire)
    );
    // Scan offsets from farthest to nearest so the nearest valid requester after the pointer wins.
    always_comb begin
        pick = ptr_q;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = 2'((int'(ptr_q) + i) % NUM_REQ);
            if (req_valid_i[idx]) pick = idx;
        end
    end
    // In SHOW the pointer is the current grant, so a dropped valid on it forces an immediate re-pick.
    always_comb begin
        any_valid = |req_valid_i;
        repick = state_q == IDLE || expire || !req_valid_i[ptr_q];
        state_d = repick ? (any_valid ? SHOW : IDLE) : state_q;
        ptr_d = repick && any_valid ? pick : ptr_q;
        grant_d = state_d == SHOW ? NUM_REQ'(1) << ptr_d : '0;
        num_d = state_d != SHOW ? '0 : val[ptr_d] > DISP_MAX ? DISP_MAX : val[ptr_d];
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q <= 2'(NUM_REQ - 1);
            grant_q <= '0;
            num_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            grant_q <= grant_d;
            num_q <= num_d;
        end
    end
    assign grant_o = grant_q;
    assign disp_en_o = state_q == SHOW;
    assign disp_num_o = num_q;
    assign dot_enables_o = 4'(grant_q);
endmodule

// File: tb/tb_quad_display_scheduler.sv
// tb_quad_display_scheduler: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_quad_display_scheduler;
    typedef struct packed {
        logic [3:0]  g;
        logic [13:0] n;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [55:0] req_value = '0;
    logic        hold = 1'b0;
    logic [3:0]  grant;
    logic        disp_en;
    logic [13:0] disp_num;
    logic [3:0]  dots;
    exp_t        q[$];
    exp_t        e_m;
    int          passed = 0;
    int          total = 0;
    int          ncyc = 0;
    quad_display_scheduler #(
        .CLOCK_FREQ_HZ (1000),
        .DWELL_MS      (4),
        .NUM_REQ       (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_value_i   (req_value),
        .hold_i        (hold),
        .grant_o       (grant),
        .disp_en_o     (disp_en),
        .disp_num_o    (disp_num),
        .dot_enables_o (dots)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        ncyc++;
        if (q.size() != 0) begin
            e_m = q.pop_front();
            total++;
            if (grant === e_m.g && disp_en === (e_m.g != 4'b0) && dots === e_m.g && disp_num === e_m.n) begin
                passed++;
            end else begin
                $display("FAIL cycle%0d: grant=%b en=%b dots=%b num=%0d, expected grant=%b en=%b dots=%b num=%0d",
                         ncyc, grant, disp_en, dots, disp_num, e_m.g, e_m.g != 4'b0, e_m.g, e_m.n);
            end
        end
    end
    task automatic setv(input int k, input int v);
        req_value[k*14 +: 14] = 14'(v);
    endtask
    task automatic cyc(input logic [3:0] g, input int n);
        q.push_back('{g: g, n: 14'(n)});
        @(negedge clk);
        #1;
    endtask
    initial begin
        int e [5];
        @(negedge clk);
        #1;
        setv(0, 1);
        setv(1, 2);
        setv(2, 3);
        setv(3, 4);
        req_valid = 4'b1111;
        repeat (2) cyc(4'b0000, 0);
        rst = 1'b0;
        e = '{1, 2, 3, 4, 1};
        for (int g = 0; g < 5; g++) begin
            for (int j = 0; j < 4; j++) begin
                if (g == 1 && j == 2) setv(1, 9999);
                if (g == 3 && j == 1) setv(3, 10000);
                cyc(4'(1 << (g % 4)), (g == 1 && j >= 2) || (g == 3 && j >= 1) ? 9999 : e[g]);
            end
        end
        req_valid = 4'b0100;
        setv(2, 16383);
        repeat (12) cyc(4'b0100, 9999);
        req_valid = 4'b0000;
        repeat (3) cyc(4'b0000, 0);
        req_valid = 4'b1000;
        setv(3, 42);
        repeat (4) cyc(4'b1000, 42);
        req_valid = 4'b1001;
        setv(0, 5);
        cyc(4'b0001, 5);
        req_valid = 4'b1000;
        cyc(4'b1000, 42);
        req_valid = 4'b1001;
        repeat (3) cyc(4'b1000, 42);
        cyc(4'b0001, 5);
        req_valid = 4'b0011;
        setv(1, 21);
        repeat (3) cyc(4'b0001, 5);
        cyc(4'b0010, 21);
        hold = 1'b1;
        repeat (10) cyc(4'b0010, 21);
        hold = 1'b0;
        repeat (3) cyc(4'b0010, 21);
        cyc(4'b0001, 5);
        repeat (3) cyc(4'b0001, 5);
        cyc(4'b0010, 21);
        hold = 1'b1;
        repeat (3) cyc(4'b0010, 21);
        req_valid = 4'b0001;
        cyc(4'b0001, 5);
        hold = 1'b0;
        req_valid = 4'b0100;
        setv(2, 77);
        repeat (2) cyc(4'b0100, 77);
        rst = 1'b1;
        req_valid = 4'b1111;
        cyc(4'b0000, 0);
        rst = 1'b0;
        repeat (2) cyc(4'b0001, 5);
        repeat (2) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
